// File: rtl/irq_collector_if.sv
// Request/response bundle for irq_collector: raw requests, mask, clear and ack in;
// registered irq, pending bits and event count out.
interface irq_collector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic [N-1:0]     clr;
    logic             ack;
    logic             irq;
    logic [N-1:0]     pending;
    logic [CNT_W-1:0] event_cnt;

    modport master (
        output req, mask, clr, ack,
        input  irq, pending, event_cnt
    );

    modport slave (
        input  req, mask, clr, ack,
        output irq, pending, event_cnt
    );
endinterface

// File: rtl/irq_collector.sv
// Sticky per-channel interrupt collector with a rate-limited assert/ack/hold-off request.
// Define IRQ_EDGE_DETECT_EN to latch rising edges of req instead of its level.
module irq_collector #(
    parameter int N     = 4,
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    irq_collector_if.slave irq_if
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam int               PC_W     = $clog2(N + 1);
    localparam int               SUM_W    = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       HOLD_V   = 8'(HOLD);
    localparam bit               NO_HOLD  = (HOLD == 0);

    logic [N-1:0]     ev;
    logic [N-1:0]     mp;
    logic [N-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             irq_q, irq_d;
    logic [PC_W-1:0]  ev_pop;
    logic [SUM_W-1:0] cnt_sum;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] req_q;

    always_ff @(posedge clk) begin
        if (rst) req_q <= '0;
        else     req_q <= irq_if.req;
    end

    assign ev = irq_if.req & ~req_q;
`else
    assign ev = irq_if.req;
`endif

    // Set dominates clear so an event landing with its own clear is never lost.
    assign pending_d = (pending_q & ~irq_if.clr) | ev;
    assign mp        = pending_q & irq_if.mask;

    always_comb begin
        ev_pop = '0;
        for (int i = 0; i < N; i++) ev_pop = ev_pop + PC_W'(ev[i]);
    end

    // Sum is wide enough to hold a full-width count plus a whole vector of events.
    assign cnt_sum = SUM_W'(cnt_q) + SUM_W'(ev_pop);
    assign cnt_d   = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (|mp) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (irq_if.ack) begin
                    if (NO_HOLD) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        timer_d = HOLD_V;
                    end
                end else if (~|mp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (timer_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // irq is its own flop so the output never decodes state bits combinationally.
    assign irq_d = (state_d == ST_ASSERT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_if.irq       = irq_q;
    assign irq_if.pending   = pending_q;
    assign irq_if.event_cnt = cnt_q;
endmodule

// File: tb/tb_irq_collector.sv
// Bench for irq_collector: u0 (HOLD=3, CNT_W=8) and u1 (HOLD=0, CNT_W=2) share stimulus.
module tb_irq_collector;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic [3:0] clr;
        logic       ack;
        logic       irq;
        logic [3:0] pend;
        logic [7:0] cnt;
        logic       chk1;
        logic       irq1;
        logic [1:0] cnt1;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0, mask = '0, clr = '0;
    logic       ack = 1'b0;
    int         checks = 0, failures = 0;
    row_t       exp_q[$];

    irq_collector_if #(.N(4), .CNT_W(8)) if0();
    irq_collector_if #(.N(4), .CNT_W(2)) if1();

    assign if0.req = req;  assign if0.mask = mask;  assign if0.clr = clr;  assign if0.ack = ack;
    assign if1.req = req;  assign if1.mask = mask;  assign if1.clr = clr;  assign if1.ack = ack;

    irq_collector #(.N(4), .HOLD(3), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .irq_if(if0.slave));
    irq_collector #(.N(4), .HOLD(0), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .irq_if(if1.slave));

    always #5 clk = ~clk;

    function automatic row_t mk(logic r, logic [3:0] rq, logic [3:0] m, logic [3:0] c, logic a,
                                logic i, logic [3:0] p, int n,
                                logic k1 = 1'b0, logic i1 = 1'b0, logic [1:0] n1 = 2'd0);
        row_t x;
        x.rst = r; x.req = rq; x.mask = m; x.clr = c; x.ack = a;
        x.irq = i; x.pend = p; x.cnt = 8'(n); x.chk1 = k1; x.irq1 = i1; x.cnt1 = n1;
        return x;
    endfunction

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 2'd0));
        rows.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 2'd0));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 5;
            if (if0.irq !== e.irq)        begin failures++; $display("FAIL reset[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)   begin failures++; $display("FAIL reset[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt)  begin failures++; $display("FAIL reset[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
            if (if1.irq !== e.irq1)       begin failures++; $display("FAIL reset[%0d] u1 irq got=%b exp=%b", i, if1.irq, e.irq1); end
            if (if1.event_cnt !== e.cnt1) begin failures++; $display("FAIL reset[%0d] u1 cnt got=%0d exp=%0d", i, if1.event_cnt, e.cnt1); end
        end
    endtask

    task automatic test_basic();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(0, 4'b0100, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 4'b0100, 1));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (if0.irq !== e.irq)       begin failures++; $display("FAIL basic[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)  begin failures++; $display("FAIL basic[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt) begin failures++; $display("FAIL basic[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
        end
    endtask

    // ack at edge k, repeated ack at k+1 must be ignored; irq back after k+4, then clr withdraws.
    task automatic test_holdoff();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 0, 4'b0100, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 0, 4'b0100, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 4'b0100, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0100, 0, 1, 4'b0000, 1));
        rows.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (if0.irq !== e.irq)       begin failures++; $display("FAIL holdoff[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)  begin failures++; $display("FAIL holdoff[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt) begin failures++; $display("FAIL holdoff[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
        end
    endtask

    task automatic test_mask_clear();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 4'b0001, 2));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 2));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 2));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 1, 4'b0001, 2));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0001, 0, 1, 4'b0000, 2));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0000, 2));
        rows.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 0, 0, 4'b0010, 3));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0010, 0, 0, 4'b0000, 3));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (if0.irq !== e.irq)       begin failures++; $display("FAIL mask_clear[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)  begin failures++; $display("FAIL mask_clear[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt) begin failures++; $display("FAIL mask_clear[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
        end
    endtask

    // req[3] held 10 cycles, clr[3] pulsed over the last 5 of them.
    task automatic test_held_req();
        row_t rows[$];
        row_t e;
        for (int i = 1; i <= 10; i++)
            rows.push_back(mk(0, 4'b1000, 4'b0000, (i >= 6) ? 4'b1000 : 4'b0000, 0, 0,
                              (EDGE && i >= 6) ? 4'b0000 : 4'b1000, EDGE ? 4 : 3 + i));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b1000, 0, 0, 4'b0000, EDGE ? 4 : 13));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (if0.irq !== e.irq)       begin failures++; $display("FAIL held[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)  begin failures++; $display("FAIL held[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt) begin failures++; $display("FAIL held[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
        end
    endtask

    // ack together with mp==0 (mask dropped) must still enter hold-off.
    task automatic test_ack_wins();
        row_t rows[$];
        row_t e;
        int   c;
        c = EDGE ? 5 : 14;
        rows.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 1, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 1, 4'b0001, c));
        rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0001, 1, 0, 4'b0000, c));
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0000, c));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (if0.irq !== e.irq)       begin failures++; $display("FAIL ack_wins[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)  begin failures++; $display("FAIL ack_wins[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt) begin failures++; $display("FAIL ack_wins[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
        end
    endtask

    task automatic test_reset_holdoff();
        row_t rows[$];
        row_t e;
        int   c;
        c = EDGE ? 7 : 16;
        rows.push_back(mk(0, 4'b1010, 4'b1010, 4'b0000, 0, 0, 4'b1010, c));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b1010, c));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 1, 0, 4'b1010, c));
        rows.push_back(mk(1, 4'b0000, 4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 2'd0));
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 0, 4'b0000, 0));
        rows.push_back(mk(0, 4'b0010, 4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 2'd1));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b0010, 1, 1, 1, 2'd1));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (if0.irq !== e.irq)       begin failures++; $display("FAIL rst_hold[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)  begin failures++; $display("FAIL rst_hold[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt) begin failures++; $display("FAIL rst_hold[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
            if (e.chk1) begin
                checks += 2;
                if (if1.irq !== e.irq1)       begin failures++; $display("FAIL rst_hold[%0d] u1 irq got=%b exp=%b", i, if1.irq, e.irq1); end
                if (if1.event_cnt !== e.cnt1) begin failures++; $display("FAIL rst_hold[%0d] u1 cnt got=%0d exp=%0d", i, if1.event_cnt, e.cnt1); end
            end
        end
    endtask

    // u1 (no hold-off) drops irq for one cycle; u0 waits out HOLD.
    task automatic test_back_to_back();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 1, 0, 4'b0010, 1, 1, 0, 2'd1));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 1, 2'd1));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 1, 2'd1));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 1, 2'd1));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b0010, 1, 1, 1, 2'd1));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 5;
            if (if0.irq !== e.irq)        begin failures++; $display("FAIL b2b[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)   begin failures++; $display("FAIL b2b[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt)  begin failures++; $display("FAIL b2b[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
            if (if1.irq !== e.irq1)       begin failures++; $display("FAIL b2b[%0d] u1 irq got=%b exp=%b", i, if1.irq, e.irq1); end
            if (if1.event_cnt !== e.cnt1) begin failures++; $display("FAIL b2b[%0d] u1 cnt got=%0d exp=%0d", i, if1.event_cnt, e.cnt1); end
        end
    endtask

    task automatic test_saturate();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(0, 4'b0001, 4'b1010, 4'b0000, 0, 1, 4'b0011, 2, 1, 1, 2'd2));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b0011, 2, 1, 1, 2'd2));
        rows.push_back(mk(0, 4'b0001, 4'b1010, 4'b0000, 0, 1, 4'b0011, 3, 1, 1, 2'd3));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b0011, 3, 1, 1, 2'd3));
        rows.push_back(mk(0, 4'b0001, 4'b1010, 4'b0000, 0, 1, 4'b0011, 4, 1, 1, 2'd3));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b0011, 4, 1, 1, 2'd3));
        rows.push_back(mk(0, 4'b1111, 4'b1010, 4'b0000, 0, 1, 4'b1111, 8, 1, 1, 2'd3));
        rows.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 0, 1, 4'b1111, 8, 1, 1, 2'd3));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req; mask = rows[i].mask; clr = rows[i].clr; ack = rows[i].ack;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 5;
            if (if0.irq !== e.irq)        begin failures++; $display("FAIL sat[%0d] irq got=%b exp=%b", i, if0.irq, e.irq); end
            if (if0.pending !== e.pend)   begin failures++; $display("FAIL sat[%0d] pending got=%b exp=%b", i, if0.pending, e.pend); end
            if (if0.event_cnt !== e.cnt)  begin failures++; $display("FAIL sat[%0d] cnt got=%0d exp=%0d", i, if0.event_cnt, e.cnt); end
            if (if1.irq !== e.irq1)       begin failures++; $display("FAIL sat[%0d] u1 irq got=%b exp=%b", i, if1.irq, e.irq1); end
            if (if1.event_cnt !== e.cnt1) begin failures++; $display("FAIL sat[%0d] u1 cnt got=%0d exp=%0d", i, if1.event_cnt, e.cnt1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_holdoff();
        test_mask_clear();
        test_held_req();
        test_ack_wins();
        test_reset_holdoff();
        test_back_to_back();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
